// File: rtl/branch_seq_ctrl.sv
// Fetch/branch control sequencer: fetch (F0,F1,FETCH_MEM,F2), DECODE, brzr/brnz/brpl/brmi (BR3..BR6), exec hand-off.
// Latency: fetch 4 cycles + memory wait, decode 1, branch 4; waits on mem_ready (bounded by MEM_TIMEOUT) and exec_done.
// Optional macro BRANCH_STATS_EN adds saturating br_count/br_taken counters.
module branch_seq_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter logic [4:0]  HALT_OPCODE = 5'b11111
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic [31:0] IR,
    input  logic        CONout,
    input  logic        mem_ready,
    input  logic        exec_done,
    output logic        pc_out,
    output logic        mar_in,
    output logic        inc_pc,
    output logic        z_in,
    output logic        zlow_out,
    output logic        pc_in,
    output logic        mem_read,
    output logic        mdr_in,
    output logic        mdr_out,
    output logic        ir_in,
    output logic        grb,
    output logic        r_out,
    output logic        con_in,
    output logic        y_in,
    output logic        c_out,
    output logic        alu_add,
    output logic        exec_req,
    output logic        busy,
    output logic        halted,
    output logic        fault
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0] br_count,
    output logic [15:0] br_taken
`endif
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_F0    = 4'd1,
        S_F1    = 4'd2,
        S_FMEM  = 4'd3,
        S_F2    = 4'd4,
        S_DEC   = 4'd5,
        S_EXEC  = 4'd6,
        S_BR3   = 4'd7,
        S_BR4   = 4'd8,
        S_BR5   = 4'd9,
        S_BR6   = 4'd10,
        S_HALT  = 4'd11,
        S_FAULT = 4'd12
    } state_t;

    localparam logic [7:0] TO_LIM = 8'(MEM_TIMEOUT);

    state_t     state, state_nxt;
    logic [7:0] to_cnt, cnt_nxt;
    logic [4:0] opcode;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= S_IDLE;
            to_cnt <= '0;
        end else begin
            state  <= state_nxt;
            to_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        pc_out    = 1'b0;
        mar_in    = 1'b0;
        inc_pc    = 1'b0;
        z_in      = 1'b0;
        zlow_out  = 1'b0;
        pc_in     = 1'b0;
        mem_read  = 1'b0;
        mdr_in    = 1'b0;
        mdr_out   = 1'b0;
        ir_in     = 1'b0;
        grb       = 1'b0;
        r_out     = 1'b0;
        con_in    = 1'b0;
        y_in      = 1'b0;
        c_out     = 1'b0;
        alu_add   = 1'b0;
        exec_req  = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;
        fault     = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) state_nxt = S_F0;
            end
            S_F0: begin
                busy      = 1'b1;
                pc_out    = 1'b1;
                mar_in    = 1'b1;
                inc_pc    = 1'b1;
                z_in      = 1'b1;
                state_nxt = S_F1;
            end
            S_F1: begin
                busy      = 1'b1;
                zlow_out  = 1'b1;
                pc_in     = 1'b1;
                state_nxt = S_FMEM;
            end
            S_FMEM: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                mdr_in   = mem_ready;
                // ready on the last allowed cycle still wins over the timeout
                if (mem_ready) begin
                    state_nxt = S_F2;
                end else begin
                    cnt_nxt = to_cnt + 8'd1;
                    if (cnt_nxt == TO_LIM) state_nxt = S_FAULT;
                end
            end
            S_F2: begin
                busy      = 1'b1;
                mdr_out   = 1'b1;
                ir_in     = 1'b1;
                state_nxt = S_DEC;
            end
            S_DEC: begin
                busy = 1'b1;
                if (opcode[4:2] == 3'b110)     state_nxt = S_BR3;
                else if (opcode == HALT_OPCODE) state_nxt = S_HALT;
                else                            state_nxt = S_EXEC;
            end
            S_EXEC: begin
                busy     = 1'b1;
                exec_req = 1'b1;
                if (exec_done) state_nxt = S_F0;
            end
            S_BR3: begin
                busy      = 1'b1;
                grb       = 1'b1;
                r_out     = 1'b1;
                con_in    = 1'b1;
                state_nxt = S_BR4;
            end
            S_BR4: begin
                busy      = 1'b1;
                pc_out    = 1'b1;
                y_in      = 1'b1;
                state_nxt = S_BR5;
            end
            S_BR5: begin
                busy      = 1'b1;
                c_out     = 1'b1;
                alu_add   = 1'b1;
                z_in      = 1'b1;
                state_nxt = S_BR6;
            end
            S_BR6: begin
                busy      = 1'b1;
                zlow_out  = 1'b1;
                pc_in     = CONout;
                state_nxt = S_F0;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            br_count <= '0;
            br_taken <= '0;
        end else if (state == S_BR6) begin
            if (br_count != 16'hFFFF)           br_count <= br_count + 16'd1;
            if (CONout && br_taken != 16'hFFFF) br_taken <= br_taken + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Randomized bench for branch_seq_ctrl: instruction-level model expands each planned instruction into its per-cycle strobe trace.
module tb_branch_seq_ctrl;
    localparam int TO = 4;

    localparam logic [19:0] M_PC_OUT   = 20'd1 << 0;
    localparam logic [19:0] M_MAR_IN   = 20'd1 << 1;
    localparam logic [19:0] M_INC_PC   = 20'd1 << 2;
    localparam logic [19:0] M_Z_IN     = 20'd1 << 3;
    localparam logic [19:0] M_ZLOW_OUT = 20'd1 << 4;
    localparam logic [19:0] M_PC_IN    = 20'd1 << 5;
    localparam logic [19:0] M_MEM_READ = 20'd1 << 6;
    localparam logic [19:0] M_MDR_IN   = 20'd1 << 7;
    localparam logic [19:0] M_MDR_OUT  = 20'd1 << 8;
    localparam logic [19:0] M_IR_IN    = 20'd1 << 9;
    localparam logic [19:0] M_GRB      = 20'd1 << 10;
    localparam logic [19:0] M_R_OUT    = 20'd1 << 11;
    localparam logic [19:0] M_CON_IN   = 20'd1 << 12;
    localparam logic [19:0] M_Y_IN     = 20'd1 << 13;
    localparam logic [19:0] M_C_OUT    = 20'd1 << 14;
    localparam logic [19:0] M_ALU_ADD  = 20'd1 << 15;
    localparam logic [19:0] M_EXEC_REQ = 20'd1 << 16;
    localparam logic [19:0] M_BUSY     = 20'd1 << 17;
    localparam logic [19:0] M_HALTED   = 20'd1 << 18;
    localparam logic [19:0] M_FAULT    = 20'd1 << 19;

    logic        clk = 1'b0;
    logic        clr, run, CONout, mem_ready, exec_done;
    logic [31:0] IR;
    logic pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, mem_read, mdr_in, mdr_out, ir_in;
    logic grb, r_out, con_in, y_in, c_out, alu_add, exec_req, busy, halted, fault;
`ifdef BRANCH_STATS_EN
    logic [15:0] br_count, br_taken;
`endif

    branch_seq_ctrl #(.MEM_TIMEOUT(TO), .HALT_OPCODE(5'b11111)) dut (
        .clk(clk), .clr(clr), .run(run), .IR(IR), .CONout(CONout),
        .mem_ready(mem_ready), .exec_done(exec_done),
        .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .z_in(z_in),
        .zlow_out(zlow_out), .pc_in(pc_in), .mem_read(mem_read), .mdr_in(mdr_in),
        .mdr_out(mdr_out), .ir_in(ir_in), .grb(grb), .r_out(r_out), .con_in(con_in),
        .y_in(y_in), .c_out(c_out), .alu_add(alu_add), .exec_req(exec_req),
        .busy(busy), .halted(halted), .fault(fault)
`ifdef BRANCH_STATS_EN
        , .br_count(br_count), .br_taken(br_taken)
`endif
    );

    always #5 clk = ~clk;

    logic [19:0] act_vec;
    assign act_vec = {fault, halted, busy, exec_req, alu_add, c_out, y_in, con_in, r_out, grb,
                      ir_in, mdr_out, mdr_in, mem_read, pc_in, zlow_out, z_in, inc_pc, mar_in, pc_out};

    typedef struct {
        logic [19:0] o;
        logic [15:0] bc;
        logic [15:0] bt;
    } exp_t;
    exp_t q[$];

    int n_chk = 0;
    int n_pass = 0;
    logic [15:0] m_bc, m_bt;

    int cyc_n = 0, last_f0 = 0, f0_gap = 0, entry_gap = 0;
    int mdr_cnt = 0, mrd_cnt = 0, xr_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, e, cyc_n);
    endtask

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    // Single compare process: one expected vector is queued per driven cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("outputs", {12'b0, act_vec}, {12'b0, e.o});
`ifdef BRANCH_STATS_EN
            chk("br_count", {16'b0, br_count}, {16'b0, e.bc});
            chk("br_taken", {16'b0, br_taken}, {16'b0, e.bt});
`endif
        end
    end

    always @(negedge clk) begin
        cyc_n++;
        if (inc_pc) begin
            f0_gap  = cyc_n - last_f0;
            last_f0 = cyc_n;
        end
        if (mdr_in)   mdr_cnt++;
        if (mem_read) mrd_cnt++;
        if (exec_req) xr_cnt++;
    end

    task automatic step(input bit r, input bit mr, input bit ed, input bit co,
                        input logic [19:0] e, input bit half);
        exp_t x;
        run = r; mem_ready = mr; exec_done = ed; CONout = co;
        x.o = e; x.bc = m_bc; x.bt = m_bt;
        q.push_back(x);
        @(negedge clk);
        if (!half) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input int n, input bit rand_run, input logic [19:0] e);
        for (int i = 0; i < n; i++)
            step(rand_run ? rb() : 1'b0, rb(), rb(), rb(), e, 1'b0);
    endtask

    task automatic do_reset();
        #2;
        clr = 1'b1;
        #1;
        chk("async_clr", {12'b0, act_vec}, 32'd0);
        m_bc = '0;
        m_bt = '0;
        @(posedge clk);
        #1;
        hold(2, 1'b1, 20'd0);
        clr = 1'b0;
        hold(3, 1'b0, 20'd0);
    endtask

    task automatic start();
        step(1'b1, rb(), rb(), rb(), 20'd0, 1'b0);
    endtask

    // Expands one instruction into its cycle trace; stuck=1 when it ends in HALT or FAULT.
    task automatic do_instr(input logic [4:0] op, input int w, input bit cond, input int xn,
                            input bit abort, output bit stuck);
        stuck = 1'b0;
        IR = {op, 27'($urandom)};
        step(rb(), rb(), rb(), rb(), M_PC_OUT | M_MAR_IN | M_INC_PC | M_Z_IN | M_BUSY, 1'b0);
        entry_gap = f0_gap;
        step(rb(), rb(), rb(), rb(), M_ZLOW_OUT | M_PC_IN | M_BUSY, 1'b0);
        for (int i = 0; i < TO; i++) begin
            if (i == w) begin
                step(rb(), 1'b1, rb(), rb(), M_MEM_READ | M_MDR_IN | M_BUSY, 1'b0);
                break;
            end
            step(rb(), 1'b0, rb(), rb(), M_MEM_READ | M_BUSY, 1'b0);
        end
        if (w >= TO) begin
            stuck = 1'b1;
            return;
        end
        step(rb(), rb(), rb(), rb(), M_MDR_OUT | M_IR_IN | M_BUSY, 1'b0);
        step(rb(), rb(), rb(), rb(), M_BUSY, 1'b0);
        if (op >= 5'd24 && op <= 5'd27) begin
            step(rb(), rb(), rb(), rb(), M_GRB | M_R_OUT | M_CON_IN | M_BUSY, 1'b0);
            step(rb(), rb(), rb(), rb(), M_PC_OUT | M_Y_IN | M_BUSY, 1'b0);
            if (abort) begin
                step(rb(), rb(), rb(), rb(), M_C_OUT | M_ALU_ADD | M_Z_IN | M_BUSY, 1'b1);
                return;
            end
            step(rb(), rb(), rb(), rb(), M_C_OUT | M_ALU_ADD | M_Z_IN | M_BUSY, 1'b0);
            step(rb(), rb(), rb(), cond, M_ZLOW_OUT | (cond ? M_PC_IN : 20'd0) | M_BUSY, 1'b0);
            if (m_bc != 16'hFFFF)         m_bc = m_bc + 16'd1;
            if (cond && m_bt != 16'hFFFF) m_bt = m_bt + 16'd1;
        end else if (op == 5'b11111) begin
            stuck = 1'b1;
        end else begin
            for (int i = 0; i < xn; i++)
                step(rb(), rb(), 1'b0, rb(), M_EXEC_REQ | M_BUSY, 1'b0);
            step(rb(), rb(), 1'b1, rb(), M_EXEC_REQ | M_BUSY, 1'b0);
        end
    endtask

    initial begin
        bit s;
        int snap_a, snap_b;
        logic [4:0] op;
        clr = 1'b1; run = 1'b0; CONout = 1'b0; mem_ready = 1'b0; exec_done = 1'b0; IR = '0;
        m_bc = '0; m_bt = '0;
        do_reset();

        // taken brzr then not-taken brnz, both zero-wait
        start();
        do_instr(5'b11000, 0, 1'b1, 0, 1'b0, s);
        do_instr(5'b11001, 0, 1'b0, 0, 1'b0, s);
        chk("brzr_f0_to_f0", entry_gap, 32'd9);
`ifdef BRANCH_STATS_EN
        chk("br_count_lit", {16'b0, br_count}, 32'd2);
        chk("br_taken_lit", {16'b0, br_taken}, 32'd1);
`endif

        // three wait cycles (ready on the timeout boundary), then 5-cycle exec hand-off
        snap_a = mdr_cnt;
        snap_b = xr_cnt;
        do_instr(5'b00011, 3, 1'b0, 5, 1'b0, s);
        chk("mdr_in_pulses", mdr_cnt - snap_a, 32'd1);
        chk("exec_req_cycles", xr_cnt - snap_b, 32'd6);

        for (int n = 0; n < 40; n++) begin
            if (rb()) op = 5'(24 + $urandom_range(0, 3));
            else      op = 5'($urandom_range(0, 30));
            do_instr(op, $urandom_range(0, 3), rb(), $urandom_range(0, 4), 1'b0, s);
        end

        // clr during BR5
        do_instr(5'b11010, 1, 1'b1, 0, 1'b1, s);
        do_reset();
`ifdef BRANCH_STATS_EN
        chk("br_count_clr", {16'b0, br_count}, 32'd0);
`endif

        // memory never ready -> FAULT, run ignored
        start();
        snap_a = mrd_cnt;
        do_instr(5'b00101, TO, 1'b0, 0, 1'b0, s);
        hold(6, 1'b1, M_FAULT);
        chk("timeout_read_cycles", mrd_cnt - snap_a, 32'd4);
        chk("fault_flag", {31'b0, fault}, 32'd1);
        do_reset();

        // halt
        start();
        do_instr(5'b11111, 1, 1'b0, 0, 1'b0, s);
        chk("halted_flag", {31'b0, halted}, 32'd1);
        chk("busy_in_halt", {31'b0, busy}, 32'd0);
        hold(5, 1'b1, M_HALTED);
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/branch_seq_ctrl.md
Name: branch_seq_ctrl

Overview:
- Multi-cycle control sequencer for the CPU's fetch phase and the conditional-branch instructions brzr/brnz/brpl/brmi (opcodes 11000–11011).
- Drives the bus, register and ALU strobes that load the condition flip-flop and conditionally update PC.
- Hands every other opcode to the execute unit through a req/done handshake.
- Sits between the IR/condition flip-flop and the datapath register enables.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles to wait for mem_ready in FETCH_MEM before entering FAULT (8-bit counter; valid range 1..255).
- HALT_OPCODE, 5'b11111: IR[31:27] value that stops the sequencer.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous, active-high reset.
- run  in  1  start/resume request, sampled in IDLE.
- IR  in  32  instruction register contents; opcode is IR[31:27].
- CONout  in  1  condition flip-flop output.
- mem_ready  in  1  memory read data valid.
- exec_done  in  1  execute unit finished non-branch instruction.
- pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in  out  1 each  datapath strobes.
- mem_read, mdr_in, mdr_out, ir_in  out  1 each  memory/IR strobes.
- grb, r_out, con_in, y_in, c_out, alu_add  out  1 each  branch-path strobes.
- exec_req  out  1  hand-off to execute unit.
- busy  out  1  high in any state except IDLE, HALT, FAULT.
- halted  out  1  high in HALT.
- fault  out  1  high in FAULT.

Behaviour:
- clr is asynchronous and active-high. While asserted: state=IDLE, timeout counter=0, all outputs 0. clr asserted mid-instruction aborts immediately; no strobe survives past the clr edge.
- Outputs are Moore-decoded from state. The only Mealy terms are mdr_in (FETCH_MEM) and pc_in (BR6).
- States and strobes:
  - IDLE: no strobes. run=1 -> F0.
  - F0: pc_out, mar_in, inc_pc, z_in. -> F1.
  - F1: zlow_out, pc_in. -> FETCH_MEM.
  - FETCH_MEM: mem_read=1 every cycle. mdr_in=mem_ready. mem_ready=1 -> F2, counter cleared. Otherwise counter+1; when counter reaches MEM_TIMEOUT -> FAULT.
  - F2: mdr_out, ir_in. -> DECODE.
  - DECODE: no strobes; evaluates the new IR.
    - Opcode 11000..11011 -> BR3.
    - HALT_OPCODE -> HALT.
    - Anything else -> EXEC.
  - EXEC: exec_req=1 held until exec_done=1, then -> F0 the next cycle. exec_req drops the cycle after exec_done is seen. exec_done outside EXEC is ignored.
  - BR3: grb, r_out, con_in (condition flip-flop loads on this edge). -> BR4.
  - BR4: pc_out, y_in. -> BR5.
  - BR5: c_out, alu_add, z_in. -> BR6.
  - BR6: zlow_out=1; pc_in=CONout (the flip-flop value loaded in BR3). -> F0.
  - HALT: halted=1. Exit only by clr; run is ignored.
  - FAULT: fault=1. Exit only by clr.
- Latency:
  - Fetch: 4 cycles plus memory wait (F0, F1, ≥1 FETCH_MEM, F2), then 1 DECODE cycle.
  - Branch execution: 4 cycles (BR3–BR6). A branch with zero memory wait takes 9 cycles from F0 back to F0.
- run is ignored outside IDLE. Once started, instructions chain F0 -> … -> F0 without revisiting IDLE.
- mem_ready high on the first FETCH_MEM cycle is a zero-wait read: exactly one FETCH_MEM cycle.
- Counter boundary: FAULT is taken on the cycle the counter equals MEM_TIMEOUT with mem_ready=0. mem_ready=1 on that same cycle wins (-> F2).
- Undefined state encodings recover to IDLE.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - Adds outputs br_count[15:0] and br_taken[15:0], both reset to 0 by clr.
  - br_count increments on every BR6 cycle; br_taken increments on BR6 cycles with CONout=1.
  - Both saturate at 16'hFFFF (no wrap).
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset mid-branch: drive clr during BR5 -> all outputs 0 immediately (async), state IDLE; after release with run=0, nothing asserts.
- brzr taken: IR[31:27]=11000, CONout=1 in BR6, mem_ready=1 in first FETCH_MEM -> BR6 asserts zlow_out=1 and pc_in=1; F0 reached 9 cycles after the first F0.
- brnz not taken: IR[31:27]=11001, CONout=0 -> BR6 has zlow_out=1, pc_in=0; sequence continues to F0; BRANCH_STATS_EN build gives br_count=1, br_taken=0.
- Memory wait and timeout: MEM_TIMEOUT=4.
  - mem_ready after 3 wait cycles -> mdr_in pulses exactly once, then F2.
  - mem_ready never -> fault=1 after 4 FETCH_MEM cycles; run toggles ignored until clr.
- Execute hand-off: IR[31:27]=00011 -> exec_req=1 held for 5 cycles while exec_done=0; exec_done=1 -> next state F0, exec_req=0.
- Halt: IR[31:27]=11111 -> halted=1 and busy=0 on the cycle after DECODE; remains until clr.
